// File: rtl/cpu_defs.sv
// Shared CPU/boot constants: IMEM geometry, instruction width and loader state encoding.
package cpu_defs;

  localparam int DEF_CELL_NUMBERS = 64;
  localparam int IMEM_ADDR_W      = 6;
  localparam int WORD_W           = 32;
  localparam int DEF_IDLE_TIMEOUT = 100000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } loader_state_t;

endpackage

// File: rtl/uart_program_loader.sv
// Packs UART bytes into little-endian 32-bit words, writes them to IMEM in order,
// and holds the CPU in reset until the whole program image has landed.
module uart_program_loader
  import cpu_defs::*;
#(
  parameter int CELL_NUMBERS = DEF_CELL_NUMBERS,
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int TIMER_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(IDLE_TIMEOUT - 1);
  localparam logic [ADDR_W:0]    LAST_IDX   = (ADDR_W + 1)'(CELL_NUMBERS - 1);

  loader_state_t     r_state;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_word_idx;
  logic [23:0]       r_buf;
  logic [TIMER_W-1:0] r_timer;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_cpu_rst;
  logic              r_load_done;
  logic              r_load_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_byte_idx  <= 2'd0;
      r_word_idx  <= '0;
      r_buf       <= '0;
      r_timer     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          // A framing error poisons the whole partial word, even if a byte strobes with it.
          if (rx_frame_err) begin
            r_byte_idx <= 2'd0;
            r_buf      <= '0;
            r_timer    <= '0;
            r_load_err <= 1'b1;
          end else if (rx_valid) begin
            r_timer <= '0;
            if (r_byte_idx == 2'd3) begin
              r_mem_wdata <= {rx_data, r_buf};
              r_mem_addr  <= r_word_idx[ADDR_W-1:0];
              r_mem_we    <= 1'b1;
              r_byte_idx  <= 2'd0;
              r_buf       <= '0;
              r_word_idx  <= r_word_idx + 1'b1;
              if (r_word_idx == LAST_IDX) begin
                r_state     <= ST_DONE;
                r_load_done <= 1'b1;
              end
            end else begin
              case (r_byte_idx)
                2'd0:    r_buf[7:0]   <= rx_data;
                2'd1:    r_buf[15:8]  <= rx_data;
                default: r_buf[23:16] <= rx_data;
              endcase
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end else if (r_byte_idx != 2'd0) begin
            if (r_timer == TIMER_LAST) begin
              r_byte_idx <= 2'd0;
              r_buf      <= '0;
              r_timer    <= '0;
              r_load_err <= 1'b1;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        // First DONE cycle is the final write cycle; the core leaves reset right after it.
        ST_DONE: r_cpu_rst <= 1'b0;
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rst   = r_cpu_rst;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: bytes are driven on the falling edge,
// outputs are checked on the falling edge after the capturing rising edge.
module tb_uart_program_loader;
  import cpu_defs::*;

  localparam int CELLS = 64;
  localparam int AW    = 6;
  localparam int TMO   = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_frame_err = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;

  int n_total = 0;
  int n_pass  = 0;

  uart_program_loader #(
    .CELL_NUMBERS(CELLS),
    .ADDR_W      (AW),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_frame_err(rx_frame_err),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rst     (cpu_rst),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Called on a falling edge; returns on the falling edge after the byte was captured.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
  endtask

  task automatic frame_err(input logic with_valid, input logic [7:0] b);
    rx_frame_err = 1'b1;
    rx_valid     = with_valid;
    rx_data      = b;
    @(negedge clk);
    rx_frame_err = 1'b0;
    rx_valid     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d);
    check({tag, "_we"}, 32'(mem_we), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(a));
    check({tag, "_wdata"}, mem_wdata, d);
  endtask

  initial begin
    logic [31:0] word;

    // Reset state
    #12;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    do_reset();

    // 1: single LUI word
    send_byte(8'h37);
    send_byte(8'h05);
    send_byte(8'h00);
    check("t1_no_early_we", 32'(mem_we), 32'd0);
    send_byte(8'h00);
    check_write("t1", 6'd0, 32'h0000_0537);
    check("t1_cpu_rst_held", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    check("t1_we_one_cycle", 32'(mem_we), 32'd0);
    check("t1_cpu_rst_still", 32'(cpu_rst), 32'd1);
    check("t1_load_err", 32'(load_err), 32'd0);

    // 3: framing error mid-word, then a clean resend; then error coinciding with a byte
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    frame_err(1'b0, 8'h00);
    check("t3_load_err", 32'(load_err), 32'd1);
    send_word(32'hDDCC_BBAA);
    check_write("t3", 6'd0, 32'hDDCC_BBAA);
    send_byte(8'h01);
    frame_err(1'b1, 8'h02);
    send_word(32'h4433_2211);
    check_write("t3_simul", 6'd1, 32'h4433_2211);

    // 4: idle timeout discards a stale byte, exactly at the limit
    do_reset();
    send_byte(8'h99);
    repeat (TMO - 1) @(negedge clk);
    check("t4_err_before_limit", 32'(load_err), 32'd0);
    @(negedge clk);
    check("t4_err_at_limit", 32'(load_err), 32'd1);
    send_word(32'h0403_0201);
    check_write("t4", 6'd0, 32'h0403_0201);

    // 5: next word's first byte arrives in the mem_we cycle
    do_reset();
    send_word(32'h8765_4321);
    check_write("t5_w0", 6'd0, 32'h8765_4321);
    send_word(32'hCAFE_F00D);
    check_write("t5_w1", 6'd1, 32'hCAFE_F00D);

    // 2: full image load
    do_reset();
    for (int w = 0; w < CELLS; w++) begin
      word = {8'(4*w + 19), 8'(4*w + 18), 8'(4*w + 17), 8'(4*w + 16)};
      for (int j = 0; j < 4; j++) begin
        send_byte(word[8*j +: 8]);
        if (j == 0 && w > 0) check("t2_we_drop", 32'(mem_we), 32'd0);
      end
      check_write("t2", AW'(w), word);
      check("t2_load_done", 32'(load_done), (w == CELLS - 1) ? 32'd1 : 32'd0);
      check("t2_cpu_rst_during_write", 32'(cpu_rst), 32'd1);
    end
    @(negedge clk);
    check("t2_we_after_last", 32'(mem_we), 32'd0);
    check("t2_cpu_rst_released", 32'(cpu_rst), 32'd0);
    check("t2_load_done_sticky", 32'(load_done), 32'd1);

    // 6: bytes after DONE are ignored, then async reset and reload
    word = {8'(4*63 + 19), 8'(4*63 + 18), 8'(4*63 + 17), 8'(4*63 + 16)};
    for (int j = 0; j < 4; j++) begin
      send_byte(8'hE0 + 8'(j));
      check("t6_no_we", 32'(mem_we), 32'd0);
    end
    frame_err(1'b1, 8'h55);
    check("t6_addr_frozen", 32'(mem_addr), 32'd63);
    check("t6_wdata_frozen", mem_wdata, word);
    check("t6_done_frozen", 32'(load_done), 32'd1);
    check("t6_cpu_rst_frozen", 32'(cpu_rst), 32'd0);
    check("t6_err_frozen", 32'(load_err), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t6_async_load_done", 32'(load_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h77);
    send_byte(8'h66);
    #2 rst_n = 1'b0;
    #1;
    check("t6_midload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t6_midload_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(32'h1234_5678);
    check_write("t6_reload", 6'd0, 32'h1234_5678);
    check("t6_reload_done", 32'(load_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
